ps2_rx_fifo: RTL

Parametrised PS/2 keyboard receiver that replaces the single-register scan-code receiver. It adds input synchronisation, a clock glitch filter, full frame checking (start, odd parity, stop) and a frame timeout. Accepted bytes go into a first-word-fall-through FIFO that the CPU-side logic drains with a read strobe. It sits between the board PS/2 pins and the memory-mapped keyboard register.

---
 rtl/ps2_rx_fifo_if.sv | 41 ++++
 rtl/ps2_rx_fifo.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/ps2_rx_fifo_if.sv
// ps2_rx_fifo_if -- CPU-side port bundle of the PS/2 receiver FIFO.
//
// Signals:
//   rd_en      pop strobe from the consumer
//   clr_err    clears the sticky overflow flag
//   rd_data    FIFO head {ext, brk, code[7:0]}
//   empty/full FIFO status
//   count      current number of stored entries
//   parity_err one-cycle pulse on a parity failure
//   frame_err  one-cycle pulse on a bad start/stop bit or a frame timeout
//   overflow   sticky, set when a valid byte was dropped on a full FIFO
//
// Handshake: rd_data is valid whenever empty=0 (first-word fall-through).
// The consumer takes the head by raising rd_en for one cycle; the entry is
// consumed on the clock edge where rd_en=1 and empty=0, and rd_en while
// empty=1 has no effect. There is no back-pressure towards the PS/2 side.
interface ps2_rx_fifo_if #(
  parameter int FIFO_DEPTH = 8
) ();
  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  logic          rd_en;
  logic          clr_err;
  logic [9:0]    rd_data;
  logic          empty;
  logic          full;
  logic [CW-1:0] count;
  logic          parity_err;
  logic          frame_err;
  logic          overflow;

  modport master (
    output rd_en, clr_err,
    input  rd_data, empty, full, count, parity_err, frame_err, overflow
  );

  modport slave (
    input  rd_en, clr_err,
    output rd_data, empty, full, count, parity_err, frame_err, overflow
  );
endinterface

// File: rtl/ps2_rx_fifo.sv
// ps2_rx_fifo -- PS/2 keyboard receiver with frame checking and a
// first-word-fall-through FIFO for received scan codes.
//
// Ports:
//   clk        system clock
//   reset      asynchronous active-high reset
//   ps2_clk    raw PS/2 clock pin (asynchronous)
//   ps2_data   raw PS/2 data pin (asynchronous)
//   bus        ps2_rx_fifo_if.slave: rd_en, clr_err, rd_data, empty, full,
//              count, parity_err, frame_err, overflow
//   state_dbg  current frame FSM state (IDLE=0, DATA=1, PARITY=2, STOP=3)
//
// Parameters: FIFO_DEPTH (power of 2, >= 2), FILTER_LEN (ps2_clk glitch
// filter length in cycles), TIMEOUT_CYC (max cycles between falling edges
// inside a frame).
//
// Optional feature, macro PS2_EVENT_DECODE_EN: when defined, 0xE0 / 0xF0
// prefix bytes are folded into the ext / brk flags of the next code instead
// of being stored. When undefined every valid byte is stored as {0,0,byte}.
module ps2_rx_fifo #(
  parameter int FIFO_DEPTH  = 8,
  parameter int FILTER_LEN  = 4,
  parameter int TIMEOUT_CYC = 50000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              ps2_clk,
  input  logic              ps2_data,
  ps2_rx_fifo_if.slave      bus,
  output logic [1:0]        state_dbg
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam int FW = $clog2(FILTER_LEN + 1);
  localparam int TW = $clog2(TIMEOUT_CYC + 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_DATA   = 2'd1,
    S_PARITY = 2'd2,
    S_STOP   = 2'd3
  } state_t;

  // ---------------- input conditioning ----------------
  logic [1:0]    clk_s;
  logic [1:0]    dat_s;
  logic          filt;
  logic          filt_d;
  logic [FW-1:0] flt_cnt;
  logic          fall;
  logic          din;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      clk_s <= 2'b11;
      dat_s <= 2'b11;
    end else begin
      clk_s <= {clk_s[0], ps2_clk};
      dat_s <= {dat_s[0], ps2_data};
    end
  end

  // The filter output only follows the synchronised clock after FILTER_LEN
  // consecutive samples that differ from it; any agreeing sample restarts it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      filt    <= 1'b1;
      filt_d  <= 1'b1;
      flt_cnt <= '0;
    end else begin
      filt_d <= filt;
      if (clk_s[1] != filt) begin
        if (flt_cnt == FW'(FILTER_LEN - 1)) begin
          filt    <= clk_s[1];
          flt_cnt <= '0;
        end else begin
          flt_cnt <= flt_cnt + FW'(1);
        end
      end else begin
        flt_cnt <= '0;
      end
    end
  end

  assign fall = filt_d & ~filt;
  assign din  = dat_s[1];

  // ---------------- frame FSM ----------------
  state_t        state;
  state_t        state_n;
  logic [2:0]    bit_idx;
  logic [7:0]    shreg;
  logic          par_q;
  logic [TW-1:0] to_cnt;
  logic          shift_en;
  logic          perr_n;
  logic          ferr_n;
  logic          byte_ok;
  logic          ones_odd;

  assign ones_odd = ^{shreg, par_q};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= state_n;
  end

  always_comb begin
    state_n  = state;
    shift_en = 1'b0;
    perr_n   = 1'b0;
    ferr_n   = 1'b0;
    byte_ok  = 1'b0;
    if (state != S_IDLE && !fall && to_cnt == TW'(TIMEOUT_CYC - 1)) begin
      state_n = S_IDLE;
      ferr_n  = 1'b1;
    end else if (fall) begin
      case (state)
        S_IDLE: begin
          if (!din) state_n = S_DATA;
          else      ferr_n  = 1'b1;
        end
        S_DATA: begin
          shift_en = 1'b1;
          if (bit_idx == 3'd7) state_n = S_PARITY;
        end
        S_PARITY: state_n = S_STOP;
        S_STOP: begin
          state_n = S_IDLE;
          perr_n  = ~ones_odd;
          ferr_n  = ~din;
          byte_ok = ones_odd & din;
        end
        default: state_n = S_IDLE;
      endcase
    end
  end

  // ---------------- frame datapath / push staging ----------------
  logic       push_v;
  logic [9:0] push_data;
  logic       perr_q;
  logic       ferr_q;
`ifdef PS2_EVENT_DECODE_EN
  logic       ext_q;
  logic       brk_q;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bit_idx   <= '0;
      shreg     <= '0;
      par_q     <= 1'b0;
      to_cnt    <= '0;
      perr_q    <= 1'b0;
      ferr_q    <= 1'b0;
      push_v    <= 1'b0;
      push_data <= '0;
`ifdef PS2_EVENT_DECODE_EN
      ext_q     <= 1'b0;
      brk_q     <= 1'b0;
`endif
    end else begin
      perr_q <= perr_n;
      ferr_q <= ferr_n;
      // Timer measures the gap since the last accepted falling edge.
      if (state == S_IDLE || fall) to_cnt <= '0;
      else                         to_cnt <= to_cnt + TW'(1);
      if (state == S_IDLE) bit_idx <= '0;
      if (shift_en) begin
        shreg   <= {din, shreg[7:1]};
        bit_idx <= bit_idx + 3'd1;
      end
      if (fall && state == S_PARITY) par_q <= din;
      push_v <= 1'b0;
`ifdef PS2_EVENT_DECODE_EN
      if (perr_n || ferr_n) begin
        ext_q <= 1'b0;
        brk_q <= 1'b0;
      end else if (byte_ok) begin
        if (shreg == 8'hE0) begin
          ext_q <= 1'b1;
        end else if (shreg == 8'hF0) begin
          brk_q <= 1'b1;
        end else begin
          push_v    <= 1'b1;
          push_data <= {ext_q, brk_q, shreg};
          ext_q     <= 1'b0;
          brk_q     <= 1'b0;
        end
      end
`else
      if (byte_ok) begin
        push_v    <= 1'b1;
        push_data <= {2'b00, shreg};
      end
`endif
    end
  end

  // ---------------- FIFO ----------------
  logic [9:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] count_q;
  logic [CW-1:0] cnt_n;
  logic [9:0]    rd_data_q;
  logic [9:0]    head_n;
  logic          ovf_q;
  logic          do_pop;
  logic          do_push;
  logic          drop;

  // A pop frees a slot in the same edge, so a push into a full FIFO that
  // coincides with a pop is accepted.
  assign do_pop  = bus.rd_en && (count_q != '0);
  assign do_push = push_v && ((count_q != CW'(FIFO_DEPTH)) || do_pop);
  assign drop    = push_v && !do_push;

  always_comb begin
    cnt_n = count_q;
    if (do_push && !do_pop)      cnt_n = count_q + CW'(1);
    else if (!do_push && do_pop) cnt_n = count_q - CW'(1);
  end

  // rd_data is a register so it can hold the last head while empty. When
  // the FIFO is (or becomes) a single-entry queue fed by this edge's push,
  // the new head is the pushed byte rather than a memory slot.
  always_comb begin
    head_n = rd_data_q;
    if (cnt_n != '0) begin
      if (count_q == '0 || (count_q == CW'(1) && do_pop)) head_n = push_data;
      else if (do_pop)                                  head_n = mem[rd_ptr + AW'(1)];
      else                                              head_n = mem[rd_ptr];
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count_q   <= '0;
      rd_data_q <= '0;
      ovf_q     <= 1'b0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      count_q   <= cnt_n;
      rd_data_q <= head_n;
      if (drop)             ovf_q <= 1'b1;
      else if (bus.clr_err) ovf_q <= 1'b0;
    end
  end

  assign bus.rd_data    = rd_data_q;
  assign bus.empty      = (count_q == '0);
  assign bus.full       = (count_q == CW'(FIFO_DEPTH));
  assign bus.count      = count_q;
  assign bus.parity_err = perr_q;
  assign bus.frame_err  = ferr_q;
  assign bus.overflow   = ovf_q;
  assign state_dbg      = state;
endmodule
